// File: rtl/trace_pkg.sv
// rtl/trace_pkg.sv - shared constants, state encoding and sample coding for the trace framer
package trace_pkg;

    localparam logic [7:0] SYNC0    = 8'hA5;
    localparam logic [7:0] SYNC1    = 8'h5A;
    localparam logic [7:0] MARK_VAL = 8'hFF;
    localparam int         HDR_LEN  = 4;

    typedef enum logic [2:0] {
        IDLE,
        CAPTURE,
        SEND_HDR,
        SEND_DATA,
        SEND_CSUM,
        WAIT
    } state_t;

    // MARK_VAL is reserved for markers, so a data sample that collides is nudged down by one
    function automatic logic [7:0] store_val(input logic mark, input logic [7:0] data);
        if (mark)
            return MARK_VAL;
        else if (data == MARK_VAL)
            return MARK_VAL - 8'd1;
        else
            return data;
    endfunction

endpackage

// File: rtl/trace_ram.sv
// rtl/trace_ram.sv - DEPTH x 8 simple dual-port sample buffer with registered read
module trace_ram #(
    parameter int DEPTH = 512,
    parameter int AW    = 9
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/trace_frame_tx.sv
// rtl/trace_frame_tx.sv - captures one trace of coded samples and sends it as a framed packet
module trace_frame_tx
    import trace_pkg::*;
#(
    parameter int DEPTH = 512,
    parameter int AW    = 9
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       arm,
    input  logic       mark,
    input  logic       smp_valid,
    input  logic [7:0] smp_data,
    output logic       busy,
    output logic       arm_drop,
    output logic       frame_done,
    output logic       tx_dv,
    output logic [7:0] tx_byte,
    input  logic       tx_done
);

    localparam logic [15:0]   LEN      = 16'(DEPTH);
    localparam logic [15:0]   LAST_IDX = 16'(DEPTH + HDR_LEN);
    localparam logic [15:0]   DATA_IDX = 16'(HDR_LEN);
    localparam logic [AW-1:0] WLAST    = AW'(DEPTH - 1);

    state_t        state;
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [15:0]   bcnt;
    logic [7:0]    csum;
    logic [7:0]    rd_data;
    logic          we;
    logic [7:0]    wdata;

    logic [15:0]   nxt_idx;
    logic [7:0]    nxt_byte;
    state_t        nxt_state;
    logic          nxt_in_sum;
    logic          nxt_is_data;

    assign we    = (state == CAPTURE) && smp_valid;
    assign wdata = store_val(mark, smp_data);

    trace_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (wptr),
        .wdata (wdata),
        .raddr (rptr),
        .rdata (rd_data)
    );

    // Byte index within the frame: 0..3 header, 4..DEPTH+3 samples, DEPTH+4 checksum
    always_comb begin
        nxt_idx     = bcnt + 16'd1;
        nxt_byte    = rd_data;
        nxt_state   = SEND_DATA;
        nxt_in_sum  = (nxt_idx >= 16'd2) && (nxt_idx < LAST_IDX);
        nxt_is_data = (nxt_idx >= DATA_IDX) && (nxt_idx < LAST_IDX);
        if (nxt_idx == 16'd1) begin
            nxt_byte  = SYNC1;
            nxt_state = SEND_HDR;
        end else if (nxt_idx == 16'd2) begin
            nxt_byte  = LEN[15:8];
            nxt_state = SEND_HDR;
        end else if (nxt_idx == 16'd3) begin
            nxt_byte  = LEN[7:0];
            nxt_state = SEND_HDR;
        end else if (nxt_idx == LAST_IDX) begin
            nxt_byte  = csum;
            nxt_state = SEND_CSUM;
        end
    end

    // SEND_* mark the cycle tx_dv is high; tx_done there is too early to be real and is ignored
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            wptr       <= '0;
            rptr       <= '0;
            bcnt       <= '0;
            csum       <= '0;
            busy       <= 1'b0;
            arm_drop   <= 1'b0;
            frame_done <= 1'b0;
            tx_dv      <= 1'b0;
            tx_byte    <= '0;
        end else begin
            tx_dv      <= 1'b0;
            arm_drop   <= 1'b0;
            frame_done <= 1'b0;
            if (arm && (state != IDLE || frame_done))
                arm_drop <= 1'b1;
            case (state)
                IDLE: begin
                    if (arm && !frame_done) begin
                        state <= CAPTURE;
                        busy  <= 1'b1;
                        wptr  <= '0;
                    end
                end
                CAPTURE: begin
                    if (smp_valid) begin
                        wptr <= wptr + 1'b1;
                        if (wptr == WLAST) begin
                            state   <= SEND_HDR;
                            tx_dv   <= 1'b1;
                            tx_byte <= SYNC0;
                            bcnt    <= '0;
                            csum    <= '0;
                            rptr    <= '0;
                        end
                    end
                end
                SEND_HDR, SEND_DATA, SEND_CSUM: begin
                    state <= WAIT;
                end
                WAIT: begin
                    if (tx_done) begin
                        if (bcnt == LAST_IDX) begin
                            frame_done <= 1'b1;
                            busy       <= 1'b0;
                            state      <= IDLE;
                        end else begin
                            bcnt    <= nxt_idx;
                            tx_dv   <= 1'b1;
                            tx_byte <= nxt_byte;
                            state   <= nxt_state;
                            if (nxt_in_sum)
                                csum <= csum + nxt_byte;
                            // advancing here gives the RAM the whole WAIT to prefetch the next sample
                            if (nxt_is_data)
                                rptr <= rptr + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
